// File: rtl/sys_array_feeder.sv
// Diagonal skew feeder for the weight-stationary array; optional vec_count under SYS_FEEDER_VEC_COUNT_EN.
// Latency: element j of a vector accepted on edge t is on m_data[j] during cycle t+1+j.
// Backpressure: s_ready drops during LOAD and DRAIN, and in IDLE while a weight load is pending.
module sys_array_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_L    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 wl_req,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [ARRAY_L*DATA_WIDTH-1:0]        s_data,
    input  logic                                 s_last,
    output logic                                 weights_load,
    output logic [0:ARRAY_L-1][DATA_WIDTH-1:0]   m_data,
    output logic [ARRAY_L-1:0]                   m_valid,
    output logic                                 busy,
    output logic [15:0]                          vec_count
);
    typedef enum logic [1:0] {IDLE, LOAD, STREAM, DRAIN} state_t;

    localparam int CW = (ARRAY_L > 2) ? $clog2(ARRAY_L - 1) : 1;
    localparam logic [CW-1:0] DRAIN_INIT = CW'(ARRAY_L - 2);

    state_t                        state_q, state_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          wl_pend_q, wl_pend_d;
    logic                          weights_load_q, weights_load_d;
    logic [ARRAY_L*DATA_WIDTH-1:0] s0_dat_q, s0_dat_d;
    logic                          s0_vld_q, s0_vld_d;
    logic                          wl_any;
    logic                          accept;

    // A request seen while streaming is remembered until it can be serviced.
    assign wl_any  = wl_req | wl_pend_q;
    assign s_ready = reset_n & (((state_q == IDLE) & ~wl_any) | (state_q == STREAM));
    assign accept  = s_valid & s_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wl_pend_d      = wl_pend_q;
        case (state_q)
            IDLE: begin
                if (wl_any) begin
                    if (m_valid == '0) state_d = LOAD;
                end else if (accept) begin
                    state_d = s_last ? DRAIN : STREAM;
                    cnt_d   = DRAIN_INIT;
                end
            end
            LOAD:   state_d = IDLE;
            STREAM: begin
                if (accept && s_last) begin
                    state_d = DRAIN;
                    cnt_d   = DRAIN_INIT;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (wl_req && state_q != LOAD) wl_pend_d = 1'b1;
        if (state_d == LOAD)           wl_pend_d = 1'b0;
        weights_load_d = (state_d == LOAD);
        s0_vld_d       = accept;
        s0_dat_d       = accept ? s_data : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            wl_pend_q      <= 1'b0;
            weights_load_q <= 1'b0;
            s0_dat_q       <= '0;
            s0_vld_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wl_pend_q      <= wl_pend_d;
            weights_load_q <= weights_load_d;
            s0_dat_q       <= s0_dat_d;
            s0_vld_q       <= s0_vld_d;
        end
    end

    assign weights_load = weights_load_q;
    assign busy         = (state_q != IDLE) | (|m_valid);

    // Column j trails column 0 by j registers; bubbles carry zero data from stage 0.
    for (genvar j = 0; j < ARRAY_L; j++) begin : g_col
        if (j == 0) begin : g_direct
            assign m_data[0]  = s0_dat_q[0 +: DATA_WIDTH];
            assign m_valid[0] = s0_vld_q;
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] dat_q [j];
            logic [DATA_WIDTH-1:0] dat_d [j];
            logic [j-1:0]          vld_q, vld_d;

            always_comb begin
                dat_d[0] = s0_dat_q[j*DATA_WIDTH +: DATA_WIDTH];
                vld_d    = '0;
                vld_d[0] = s0_vld_q;
                for (int k = 1; k < j; k++) begin
                    dat_d[k] = dat_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < j; k++) dat_q[k] <= '0;
                    vld_q <= '0;
                end else begin
                    dat_q <= dat_d;
                    vld_q <= vld_d;
                end
            end

            assign m_data[j]  = dat_q[j-1];
            assign m_valid[j] = vld_q[j-1];
        end
    end

`ifdef SYS_FEEDER_VEC_COUNT_EN
    logic [15:0] vec_count_q, vec_count_d;

    always_comb begin
        vec_count_d = vec_count_q;
        if (state_d == LOAD)                         vec_count_d = '0;
        else if (accept && vec_count_q != 16'hFFFF)  vec_count_d = vec_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) vec_count_q <= '0;
        else          vec_count_q <= vec_count_d;
    end

    assign vec_count = vec_count_q;
`else
    assign vec_count = '0;
`endif
endmodule

// File: tb/tb_sys_array_feeder.sv
// Testbench for sys_array_feeder: directed tables, corner sequences and a randomized stream vs. a reference model.
module tb_sys_array_feeder;
    localparam int L  = 4;
    localparam int DW = 8;
    localparam int N  = 300;
    localparam int NC = N + 16;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;
`ifdef SYS_FEEDER_VEC_COUNT_EN
    localparam bit VC_EN = 1'b1;
`else
    localparam bit VC_EN = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     wl_req, s_valid, s_last, s_ready, weights_load, busy;
    logic [L*DW-1:0]          s_data;
    logic [0:L-1][DW-1:0]     m_data;
    logic [L-1:0]             m_valid;
    logic [15:0]              vec_count;

    int n_tests = 0;
    int n_fail  = 0;

    sys_array_feeder #(.DATA_WIDTH(DW), .ARRAY_L(L)) dut (
        .clk(clk), .reset_n(reset_n), .wl_req(wl_req), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .weights_load(weights_load), .m_data(m_data), .m_valid(m_valid),
        .busy(busy), .vec_count(vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wl, sv, sl;
        logic [31:0] sd;
        logic        rdy, wld, bsy;
        logic [3:0]  vld;
        logic [31:0] dat;
        logic [15:0] vc;
    } vec_t;

    vec_t tbl_a[$];
    vec_t tbl_b[$];

    function automatic vec_t mk(logic wl, logic sv, logic sl, logic [31:0] sd, logic rdy,
                                logic wld, logic bsy, logic [3:0] vld, logic [31:0] dat,
                                logic [15:0] vc);
        vec_t r;
        r.wl = wl; r.sv = sv; r.sl = sl; r.sd = sd; r.rdy = rdy; r.wld = wld;
        r.bsy = bsy; r.vld = vld; r.dat = dat; r.vc = vc;
        return r;
    endfunction

    // Element j of the output bus placed at byte j.
    function automatic logic [31:0] md_flat();
        logic [31:0] f;
        for (int j = 0; j < L; j++) f[j*DW +: DW] = m_data[j];
        return f;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_table(input string tag, input vec_t t[$]);
        for (int i = 0; i < t.size(); i++) begin
            @(negedge clk);
            wl_req = t[i].wl; s_valid = t[i].sv; s_last = t[i].sl; s_data = t[i].sd;
            #1;
            chk($sformatf("%s_row%0d {rdy,wl,busy,vld,dat,vc}", tag, i),
                {s_ready, weights_load, busy, m_valid, md_flat(), vec_count},
                {t[i].rdy, t[i].wld, t[i].bsy, t[i].vld, t[i].dat, (VC_EN ? t[i].vc : 16'd0)});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ev [NC];
        logic [31:0] ed [NC];
        int          last_v, strobe, n_strobe, acc, drain_end;
        bit          overlap, leak, in_stream, rdy_m, bsy_m, sv, sl;
        logic [31:0] sd;

        reset_n = 1'b0; wl_req = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;

        // Single load followed by one vector with s_last.
        tbl_a.push_back(mk(1,0,0,0,            0,0,0,4'b0000,32'h0,0));
        tbl_a.push_back(mk(0,0,0,0,            0,1,1,4'b0000,32'h0,0));
        tbl_a.push_back(mk(0,1,1,32'h04030201, 1,0,0,4'b0000,32'h0,0));
        tbl_a.push_back(mk(0,1,0,JUNK,         0,0,1,4'b0001,32'h00000001,1));
        tbl_a.push_back(mk(0,1,0,JUNK,         0,0,1,4'b0010,32'h00000200,1));
        tbl_a.push_back(mk(0,1,0,JUNK,         0,0,1,4'b0100,32'h00030000,1));
        tbl_a.push_back(mk(0,0,0,0,            1,0,1,4'b1000,32'h04000000,1));
        tbl_a.push_back(mk(0,0,0,0,            1,0,0,4'b0000,32'h0,1));
        // Load (clears count), then A, B, bubble, C with s_last.
        tbl_b.push_back(mk(1,0,0,0,            0,0,0,4'b0000,32'h0,1));
        tbl_b.push_back(mk(0,0,0,0,            0,1,1,4'b0000,32'h0,0));
        tbl_b.push_back(mk(0,1,0,32'h14131211, 1,0,0,4'b0000,32'h0,0));
        tbl_b.push_back(mk(0,1,0,32'h24232221, 1,0,1,4'b0001,32'h00000011,1));
        tbl_b.push_back(mk(0,0,0,0,            1,0,1,4'b0011,32'h00001221,2));
        tbl_b.push_back(mk(0,1,1,32'h34333231, 1,0,1,4'b0110,32'h00132200,2));
        tbl_b.push_back(mk(0,1,0,JUNK,         0,0,1,4'b1101,32'h14230031,3));
        tbl_b.push_back(mk(0,1,0,JUNK,         0,0,1,4'b1010,32'h24003200,3));
        tbl_b.push_back(mk(0,1,0,JUNK,         0,0,1,4'b0100,32'h00330000,3));
        tbl_b.push_back(mk(0,0,0,0,            1,0,1,4'b1000,32'h34000000,3));
        tbl_b.push_back(mk(0,0,0,0,            1,0,0,4'b0000,32'h0,3));

        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {s_ready, weights_load, busy, m_valid, md_flat(), vec_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset {rdy,busy,wl,vld}", {s_ready, busy, weights_load, m_valid}, 7'b1000000);

        run_table("single", tbl_a);
        run_table("bubble", tbl_b);

        // Weight load requested mid-stream must wait for the skew stages to empty.
        @(negedge clk);
        s_valid = 1'b1; s_last = 1'b0; s_data = 32'h44434241; #1;
        chk("wl_stream_start_rdy", s_ready, 1);
        @(negedge clk);
        wl_req = 1'b1; s_last = 1'b1; s_data = 32'h54535251; #1;
        chk("wl_stream_rdy_ignores_req", s_ready, 1);
        last_v = -1; strobe = -1; n_strobe = 0; overlap = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0; #1;
            if (weights_load && m_valid != '0) overlap = 1;
            if (m_valid != '0) last_v = k;
            if (k == 5) chk("wl_pending_rdy", s_ready, 0);
            if (weights_load) begin
                n_strobe++;
                if (strobe < 0) strobe = k;
                wl_req = 1'b0;
            end
        end
        chk("wl_last_valid_cycle", last_v, 4);
        chk("wl_strobe_cycle", strobe, 6);
        chk("wl_strobe_count", n_strobe, 1);
        chk("wl_overlap_with_valid", overlap, 0);

        // Reset asserted while the last vector is still draining.
        @(negedge clk);
        s_valid = 1'b1; s_last = 1'b1; s_data = 32'h04030201; #1;
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0; #1;
        chk("rst_c1 {vld,dat}", {m_valid, md_flat()}, {4'b0001, 32'h00000001});
        @(negedge clk);
        reset_n = 1'b0; #1;
        chk("rst_mid_clear {vld,dat,rdy,busy}", {m_valid, md_flat(), s_ready, busy}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        leak = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            if (m_valid != '0 || md_flat() != '0) leak = 1;
        end
        chk("rst_no_leak", leak, 0);
        chk("rst_rdy_after", s_ready, 1);

        // Randomized stream against a cycle-indexed expectation table.
        for (int c = 0; c < NC; c++) begin
            ev[c] = '0;
            ed[c] = '0;
        end
        in_stream = 0; drain_end = 0; acc = 0;
        for (int c = 0; c < N + 8; c++) begin
            @(negedge clk);
            rdy_m = (c >= drain_end);
            sv = (c < N) ? ($urandom_range(0, 9) < 7) : 1'b0;
            sl = ($urandom_range(0, 5) == 0);
            sd = $urandom;
            s_valid = sv; s_last = sl; s_data = sd;
            #1;
            bsy_m = in_stream || (c < drain_end) || (ev[c] != '0);
            chk($sformatf("rand_c%0d {rdy,busy,wl,vld,dat,vc}", c),
                {s_ready, busy, weights_load, m_valid, md_flat(), vec_count},
                {rdy_m, bsy_m, 1'b0, ev[c], ed[c], (VC_EN ? acc[15:0] : 16'd0)});
            if (sv && rdy_m) begin
                for (int j = 0; j < L; j++) begin
                    ev[c+1+j][j] = 1'b1;
                    ed[c+1+j][j*DW +: DW] = sd[j*DW +: DW];
                end
                acc++;
                if (sl) begin
                    in_stream = 0;
                    drain_end = c + L;
                end else begin
                    in_stream = 1;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
